// File: rtl/vga_timing_driver.sv
// VGA raster timing generator: free-running h/v counters, registered sync/DE, and a
// pixel request bus that leads active video by LAT cycles so returned data lines up with DE.
module vga_timing_driver #(
   parameter int unsigned H_SYNC  = 96,
   parameter int unsigned H_BACK  = 48,
   parameter int unsigned H_DISP  = 640,
   parameter int unsigned H_FRONT = 16,
   parameter int unsigned V_SYNC  = 2,
   parameter int unsigned V_BACK  = 33,
   parameter int unsigned V_DISP  = 480,
   parameter int unsigned V_FRONT = 10,
   parameter int unsigned HS_POL  = 0,
   parameter int unsigned VS_POL  = 0,
   parameter int unsigned LAT     = 1
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [15:0] pixel_data,
   output logic [10:0] pixel_xpos,
   output logic [10:0] pixel_ypos,
   output logic        pixel_req,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_de,
   output logic [15:0] vga_rgb,
   output logic        frame_start
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_DISP + H_FRONT;
   localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_DISP + V_FRONT;
   localparam int unsigned H_START = H_SYNC + H_BACK;
   localparam int unsigned V_START = V_SYNC + V_BACK;

   localparam logic [10:0] HLast    = 11'(H_TOTAL - 1);
   localparam logic [10:0] VLast    = 11'(V_TOTAL - 1);
   localparam logic [10:0] HSyncEnd = 11'(H_SYNC);
   localparam logic [10:0] VSyncEnd = 11'(V_SYNC);
   localparam logic [10:0] HStart   = 11'(H_START);
   localparam logic [10:0] HEnd     = 11'(H_START + H_DISP);
   localparam logic [10:0] VStart   = 11'(V_START);
   localparam logic [10:0] VEnd     = 11'(V_START + V_DISP);
   localparam logic [11:0] HStartW  = 12'(H_START);
   localparam logic [11:0] HEndW    = 12'(H_START + H_DISP);
   localparam logic [11:0] LatW     = 12'(LAT);
   localparam logic        HsAct    = 1'(HS_POL);
   localparam logic        VsAct    = 1'(VS_POL);

   logic [10:0] h_cnt_q, h_cnt_d;
   logic [10:0] v_cnt_q, v_cnt_d;
   logic        hs_q, hs_d;
   logic        vs_q, vs_d;
   logic        de_q, de_d;
   logic        req_q, req_d;
   logic [10:0] xpos_q, xpos_d;
   logic [10:0] ypos_q, ypos_d;
   logic        fs_q, fs_d;

   logic        h_wrap;
   logic        v_win;
   logic [11:0] hr;

   always_comb begin
      h_wrap  = (h_cnt_q == HLast);
      h_cnt_d = h_wrap ? 11'd0 : h_cnt_q + 11'd1;
      v_cnt_d = v_cnt_q;
      if (h_wrap) begin
         v_cnt_d = (v_cnt_q == VLast) ? 11'd0 : v_cnt_q + 11'd1;
      end

      v_win = (v_cnt_q >= VStart) && (v_cnt_q < VEnd);
      // 12-bit look-ahead so h_cnt+LAT past the line end cannot wrap into the window
      hr    = {1'b0, h_cnt_q} + LatW;

      hs_d  = (h_cnt_q < HSyncEnd) ? HsAct : ~HsAct;
      vs_d  = (v_cnt_q < VSyncEnd) ? VsAct : ~VsAct;
      de_d  = (h_cnt_q >= HStart) && (h_cnt_q < HEnd) && v_win;
      req_d = (hr >= HStartW) && (hr < HEndW) && v_win;
      fs_d  = (h_cnt_q == 11'd0) && (v_cnt_q == 11'd0);

      xpos_d = 11'd0;
      ypos_d = 11'd0;
      if (req_d) begin
         xpos_d = 11'(hr - HStartW);
         ypos_d = v_cnt_q - VStart;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         h_cnt_q <= 11'd0;
         v_cnt_q <= 11'd0;
         hs_q    <= ~HsAct;
         vs_q    <= ~VsAct;
         de_q    <= 1'b0;
         req_q   <= 1'b0;
         xpos_q  <= 11'd0;
         ypos_q  <= 11'd0;
         fs_q    <= 1'b0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
         hs_q    <= hs_d;
         vs_q    <= vs_d;
         de_q    <= de_d;
         req_q   <= req_d;
         xpos_q  <= xpos_d;
         ypos_q  <= ypos_d;
         fs_q    <= fs_d;
      end
   end

   assign pixel_xpos  = xpos_q;
   assign pixel_ypos  = ypos_q;
   assign pixel_req   = req_q;
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;
   assign vga_de      = de_q;
   assign frame_start = fs_q;
   // Blanking must never reach the DAC, whatever the display path returns
   assign vga_rgb     = de_q ? pixel_data : 16'h0000;

endmodule

// File: tb/tb_vga_timing_driver.sv
// Directed bench for vga_timing_driver on a shrunken raster (18x10), LAT=1 and LAT=3 instances.
module tb_vga_timing_driver;

   // Small raster: H_TOTAL=18, H_START=7, V_TOTAL=10, V_START=4, frame=180 cycles
   localparam int HT  = 18;
   localparam int FRM = 180;

   logic        clk;
   logic        rstn;
   logic        force_ff;
   logic [15:0] pd1, pd3;
   logic [15:0] d1_q;
   logic [15:0] p3_q [3];
   logic [10:0] xpos1, ypos1, xpos3, ypos3;
   logic        req1, req3, hs1, hs3, vs1, vs3, de1, de3, fs1, fs3;
   logic [15:0] rgb1, rgb3;

   int tests;
   int failures;
   int n;

   int          last_hs_fall, last_fs, hs_low, vs_low, de_len, lines;
   logic        prev_hs, prev_vs, prev_de, prev_fs, hist1;
   logic [2:0]  hist3;
   logic [10:0] col, row;

   vga_timing_driver #(
      .H_SYNC(4), .H_BACK(3), .H_DISP(8), .H_FRONT(3),
      .V_SYNC(2), .V_BACK(2), .V_DISP(4), .V_FRONT(2),
      .HS_POL(0), .VS_POL(0), .LAT(1)
   ) u_dut1 (
      .clk(clk), .rstn(rstn), .pixel_data(pd1),
      .pixel_xpos(xpos1), .pixel_ypos(ypos1), .pixel_req(req1),
      .vga_hs(hs1), .vga_vs(vs1), .vga_de(de1), .vga_rgb(rgb1), .frame_start(fs1)
   );

   vga_timing_driver #(
      .H_SYNC(4), .H_BACK(3), .H_DISP(8), .H_FRONT(3),
      .V_SYNC(2), .V_BACK(2), .V_DISP(4), .V_FRONT(2),
      .HS_POL(0), .VS_POL(0), .LAT(3)
   ) u_dut3 (
      .clk(clk), .rstn(rstn), .pixel_data(pd3),
      .pixel_xpos(xpos3), .pixel_ypos(ypos3), .pixel_req(req3),
      .vga_hs(hs3), .vga_vs(vs3), .vga_de(de3), .vga_rgb(rgb3), .frame_start(fs3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Display-path model: returns {x[4:0], y} after 1 or 3 register stages
   always @(posedge clk) begin
      d1_q    <= {xpos1[4:0], ypos1};
      p3_q[0] <= {xpos3[4:0], ypos3};
      p3_q[1] <= p3_q[0];
      p3_q[2] <= p3_q[1];
   end
   assign pd1 = force_ff ? 16'hFFFF : d1_q;
   assign pd3 = force_ff ? 16'hFFFF : p3_q[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h (n=%0d)", tag, obs, exp, n);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      n++;
   endtask

   task automatic chk_reset_vals();
      chk("rst_hs1", hs1, 1);      chk("rst_vs1", vs1, 1);
      chk("rst_de1", de1, 0);      chk("rst_req1", req1, 0);
      chk("rst_x1", xpos1, 0);     chk("rst_y1", ypos1, 0);
      chk("rst_rgb1", rgb1, 0);    chk("rst_fs1", fs1, 0);
      chk("rst_hs3", hs3, 1);      chk("rst_vs3", vs3, 1);
      chk("rst_de3", de3, 0);      chk("rst_req3", req3, 0);
      chk("rst_x3", xpos3, 0);     chk("rst_y3", ypos3, 0);
      chk("rst_rgb3", rgb3, 0);    chk("rst_fs3", fs3, 0);
   endtask

   task automatic init_mon();
      prev_hs = 1'b1; prev_vs = 1'b1; prev_de = 1'b0; prev_fs = 1'b0;
      last_hs_fall = -1; last_fs = -1;
      hs_low = 0; vs_low = 0; de_len = 0; lines = 0;
      col = '0; row = '0; hist1 = 1'b0; hist3 = '0;
   endtask

   task automatic mon_cycle();
      logic [15:0] exp_px;
      if (n == 1) begin
         chk("first_fs", fs1, 1); chk("first_hs", hs1, 0); chk("first_vs", vs1, 0);
         chk("first_fs3", fs3, 1);
      end
      if (n == 2) chk("fs_one_cycle", fs1, 0);
      if (n == 77) begin chk("req3_first", req3, 1); chk("x3_first", xpos3, 0); end
      if (n == 79) begin chk("req1_first", req1, 1); chk("x1_first", xpos1, 0); end
      if (n == 80) begin chk("first_px_de", de1, 1); chk("first_px", rgb1, 16'h0000); end
      if (n == 140) begin chk("last_req_x", xpos1, 7); chk("last_req_y", ypos1, 3); end
      if (n == 141) chk("last_px", rgb1, 16'h3803);

      if (prev_hs && !hs1) begin
         if (last_hs_fall >= 0) chk("h_period", n - last_hs_fall, HT);
         last_hs_fall = n;
         hs_low = 0;
      end
      if (!hs1) hs_low++;
      if (!prev_hs && hs1) chk("hs_width", hs_low, 4);

      if (prev_vs && !vs1) vs_low = 0;
      if (!vs1) vs_low++;
      if (!prev_vs && vs1) chk("vs_width", vs_low, 2 * HT);

      if (fs1) begin
         chk("fs_pulse", prev_fs, 0);
         if (last_fs >= 0) begin
            chk("frame_period", n - last_fs, FRM);
            chk("de_lines", lines, 4);
         end
         last_fs = n; lines = 0; row = '0;
      end

      if (!prev_de && de1) begin
         if (last_hs_fall >= 0) chk("de_delay", n - last_hs_fall, 7);
         col = '0; de_len = 0;
      end
      if (de1) begin
         exp_px = force_ff ? 16'hFFFF : {col[4:0], row};
         chk("rgb1_px", rgb1, exp_px);
         chk("rgb3_px", rgb3, exp_px);
         col++; de_len++;
      end else begin
         chk("rgb1_blank", rgb1, 0);
         chk("rgb3_blank", rgb3, 0);
      end
      if (prev_de && !de1) begin
         chk("de_width", de_len, 8);
         row++; lines++;
      end

      chk("lead1", de1, hist1);
      chk("lead3", de3, hist3[2]);
      hist1 = req1;
      hist3 = {hist3[1:0], req3};
      prev_hs = hs1; prev_vs = vs1; prev_de = de1; prev_fs = fs1;
   endtask

   task automatic run(input int cycles);
      for (int i = 0; i < cycles; i++) begin
         step();
         mon_cycle();
      end
   endtask

   initial begin
      tests = 0; failures = 0; n = 0;
      force_ff = 1'b0;
      rstn = 1'b0;
      init_mon();
      repeat (10) step();
      chk_reset_vals();

      @(negedge clk);
      rstn = 1'b1;
      n = 0;
      init_mon();
      run(400);

      force_ff = 1'b1;
      run(200);
      force_ff = 1'b0;

      // Advance to line 6, column 10 (inside active video) for the mid-frame reset
      for (int i = 0; i < 200; i++) begin
         if (((n - 1) % FRM) == 6 * HT + 10) break;
         step();
         mon_cycle();
      end
      chk("sync_point", ((n - 1) % FRM), 6 * HT + 10);
      chk("pre_rst_de", de1, 1);

      rstn = 1'b0;
      #1;
      chk_reset_vals();
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals();

      @(negedge clk);
      rstn = 1'b1;
      n = 0;
      init_mon();
      run(200);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule

// File: doc/vga_timing_driver.md
Name: vga_timing_driver

Overview:
Generates VGA raster timing and drives the pixel-coordinate request bus consumed by the game display path. Each cycle it issues `pixel_xpos`/`pixel_ypos` for a future pixel and accepts RGB565 `pixel_data` back a fixed number of cycles later. It produces the sync, data-enable and RGB outputs for the DAC/connector. It also emits a frame-start pulse that the game logic uses as its frame tick.

Parameters:
- H_SYNC, 96, horizontal sync width (clk cycles)
- H_BACK, 48, horizontal back porch
- H_DISP, 640, horizontal active pixels
- H_FRONT, 16, horizontal front porch
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch
- V_DISP, 480, vertical active lines
- V_FRONT, 10, vertical front porch
- HS_POL, 0, hsync active level
- VS_POL, 0, vsync active level
- LAT, 1, upstream latency in cycles from `pixel_xpos`/`pixel_ypos` to `pixel_data`; legal range 1..H_FRONT

Ports:
- clk  input  1  pixel clock
- rstn  input  1  reset
- pixel_data  input  16  RGB565 returned by the display path, valid LAT cycles after the matching request
- pixel_xpos  output  11  requested column, 0..H_DISP-1
- pixel_ypos  output  11  requested row, 0..V_DISP-1
- pixel_req  output  1  high when `pixel_xpos`/`pixel_ypos` name an active pixel
- vga_hs  output  1  horizontal sync
- vga_vs  output  1  vertical sync
- vga_de  output  1  active-video enable
- vga_rgb  output  16  RGB565 to the DAC
- frame_start  output  1  one-cycle pulse at the start of each frame

Behaviour:
- Interface: reset rstn, asynchronous, active-low; clock clk.
- Derived constants:
  - H_TOTAL = H_SYNC+H_BACK+H_DISP+H_FRONT (800).
  - V_TOTAL = V_SYNC+V_BACK+V_DISP+V_FRONT (525).
  - H_START = H_SYNC+H_BACK.
  - V_START = V_SYNC+V_BACK.
- Counters:
  - h_cnt counts 0..H_TOTAL-1 and wraps to 0.
  - v_cnt increments only on the cycle h_cnt wraps; it counts 0..V_TOTAL-1 and wraps to 0.
  - Both reset to 0.
- Registered outputs. Each is updated at edge t+1 from the counter values at edge t.
  - vga_hs = HS_POL when h_cnt < H_SYNC, else ~HS_POL.
  - vga_vs = VS_POL when v_cnt < V_SYNC, else ~VS_POL.
  - vga_de = 1 when H_START ≤ h_cnt < H_START+H_DISP and V_START ≤ v_cnt < V_START+V_DISP.
  - Request window: hr = h_cnt+LAT. pixel_req = 1 when H_START ≤ hr < H_START+H_DISP and v_cnt is in the vertical window.
  - When pixel_req=1: pixel_xpos = hr-H_START and pixel_ypos = v_cnt-V_START. Otherwise both are 0.
  - frame_start = 1 when h_cnt==0 and v_cnt==0.
- Alignment: a request issued at cycle t+1 is for the pixel where vga_de rises or continues at cycle t+1+LAT. No line-boundary crossing is possible because LAT ≤ H_FRONT < H_START.
- vga_rgb is combinational: pixel_data when vga_de=1, else 16'h0000. It is never driven during blanking.
- Reset values of all outputs:
  - vga_hs = ~HS_POL, vga_vs = ~VS_POL (both inactive)
  - vga_de = 0, pixel_req = 0, frame_start = 0
  - pixel_xpos = 0, pixel_ypos = 0
  - vga_rgb = 0
- First edge after reset release: vga_hs and vga_vs go active and frame_start = 1.
- Reset mid-frame: all state returns immediately to the reset values above. Timing restarts at h_cnt=0, v_cnt=0 with no partial-frame completion.
- Width rules:
  - Counters are 11 bits.
  - hr is computed at 12 bits so that h_cnt+LAT near H_TOTAL cannot alias into the window.

Test Plan:
- Reset hold:
  - Stimulus: assert rstn=0 for 10 cycles.
  - Required: vga_hs=1, vga_vs=1, vga_de=0, pixel_req=0, xpos=ypos=0, vga_rgb=0.
  - After release: frame_start pulses exactly 1 cycle on the first edge.
- Line timing (defaults):
  - vga_hs low for 96 cycles, period 800.
  - vga_de high 640 cycles per active line, rising 144 cycles after vga_hs falls.
- Frame timing:
  - vga_vs low for 1600 cycles, period 420000.
  - frame_start spacing 420000.
  - Exactly 480 lines contain vga_de=1.
- Data alignment, LAT=1:
  - Stimulus: a bench model returns pixel_data = {xpos[4:0], ypos[10:0]} registered once.
  - Required: during vga_de, vga_rgb equals {col[4:0], row} for every pixel.
  - First pixel of row 0 = 16'h0000. Last pixel of row 479 = {5'd31, 11'd479}.
- Blanking mask:
  - Stimulus: hold pixel_data=16'hFFFF.
  - Required: vga_rgb=0 whenever vga_de=0, and 16'hFFFF otherwise.
- LAT=3 rebuild plus mid-frame reset:
  - Required: pixel_req leads vga_de by 3 cycles, and the same alignment check passes.
  - Stimulus: pulse rstn low at line 200, column 300.
  - Required: outputs return to reset values immediately, and the next frame_start occurs 1 cycle after release.
